// File: rtl/multdiv_unit_if.sv
// Request/response bundle between pipeline control and the iterative multiplier/divider.
//   master : pipeline control -- drives start pulses and operands, receives result/flags
//   slave  : multdiv_unit     -- receives start pulses and operands, drives result/flags
//   ctrl_MULT, ctrl_DIV           : one-cycle start pulses
//   data_operandA, data_operandB  : signed 32-bit operands, sampled in the start cycle
//   data_result, data_exception   : result word and overflow/divide-by-zero flag
//   data_resultRDY                : one-cycle strobe marking result/flag valid
//   busy                          : operation in flight
interface multdiv_unit_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiplier (radix-2 Booth) / divider (non-restoring on magnitudes).
// One iteration per cycle, 32 iterations; result, exception and a one-cycle ready strobe
// appear 33 cycles after the start cycle. A new start pulse aborts any operation in flight.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : multdiv_unit_if.slave (start pulses, operands, result, exception, ready, busy)
module multdiv_unit (
    input  logic          clock,
    input  logic          reset,
    multdiv_unit_if.slave bus
);
    localparam int unsigned DW = 32;          // datapath width
    localparam int unsigned CW = 5;           // iteration counter width
    localparam int unsigned BW = 2 * DW + 1;  // Booth register {acc, multiplier, q-1}
    localparam int unsigned RW = DW + 2;      // signed partial remainder width

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [DW-1:0] mcand, mcand_next;
    logic [BW-1:0] booth, booth_next;
    logic [DW-1:0] dvs, dvs_next;
    logic [RW-1:0] rem, rem_next;
    logic [DW-1:0] quot, quot_next;
    logic          neg, neg_next;
    logic          dz, dz_next;
    logic [DW-1:0] result, result_next;
    logic          exc, exc_next;
    logic          rdy, rdy_next;
    logic          busy_r, busy_next;

    logic [DW:0]     booth_sum;
    logic [BW-1:0]   booth_step;
    logic [2*DW-1:0] product;
    logic [RW-1:0]   rem_sh, rem_step;
    logic [DW-1:0]   quot_step;
    logic [DW-1:0]   mag_a, mag_b;

    // Booth step: add/subtract in 33 bits so the true sign is shifted in even when
    // the 32-bit accumulator would overflow (e.g. multiplicand = 0x80000000).
    always_comb begin
        booth_sum = {booth[BW-1], booth[BW-1 -: DW]};
        case (booth[1:0])
            2'b01:   booth_sum = {booth[BW-1], booth[BW-1 -: DW]} + {mcand[DW-1], mcand};
            2'b10:   booth_sum = {booth[BW-1], booth[BW-1 -: DW]} - {mcand[DW-1], mcand};
            default: booth_sum = {booth[BW-1], booth[BW-1 -: DW]};
        endcase
        booth_step = {booth_sum, booth[DW:1]};
        product    = booth_step[BW-1:1];
    end

    // Non-restoring step: shift in next dividend bit, then subtract or add back the divisor.
    always_comb begin
        rem_sh    = {rem[RW-2:0], quot[DW-1]};
        rem_step  = rem[RW-1] ? (rem_sh + {2'b00, dvs}) : (rem_sh - {2'b00, dvs});
        quot_step = {quot[DW-2:0], ~rem_step[RW-1]};
    end

    // Operand magnitudes; 0x80000000 maps to its unsigned magnitude 2^31.
    always_comb begin
        mag_a = bus.data_operandA[DW-1] ? (DW'(0) - bus.data_operandA) : bus.data_operandA;
        mag_b = bus.data_operandB[DW-1] ? (DW'(0) - bus.data_operandB) : bus.data_operandB;
    end

    // Next-state and output logic.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        mcand_next  = mcand;
        booth_next  = booth;
        dvs_next    = dvs;
        rem_next    = rem;
        quot_next   = quot;
        neg_next    = neg;
        dz_next     = dz;
        result_next = result;
        exc_next    = exc;
        rdy_next    = 1'b0;
        busy_next   = busy_r;

        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            // Start (or restart) from any state; multiply wins a simultaneous request.
            state_next = bus.ctrl_MULT ? MULT : DIV;
            cnt_next   = '0;
            busy_next  = 1'b1;
            mcand_next = bus.data_operandA;
            booth_next = {DW'(0), bus.data_operandB, 1'b0};
            dvs_next   = mag_b;
            rem_next   = '0;
            quot_next  = mag_a;
            neg_next   = bus.data_operandA[DW-1] ^ bus.data_operandB[DW-1];
            dz_next    = (bus.data_operandB == '0);
        end else begin
            case (state)
                MULT: begin
                    booth_next = booth_step;
                    cnt_next   = cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
                        state_next  = DONE;
                        cnt_next    = '0;
                        busy_next   = 1'b0;
                        rdy_next    = 1'b1;
                        result_next = product[DW-1:0];
                        exc_next    = ~((&product[2*DW-1:DW-1]) | ~(|product[2*DW-1:DW-1]));
                    end
                end
                DIV: begin
                    rem_next  = rem_step;
                    quot_next = quot_step;
                    cnt_next  = cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
                        state_next = DONE;
                        cnt_next   = '0;
                        busy_next  = 1'b0;
                        rdy_next   = 1'b1;
                        if (dz) begin
                            result_next = '0;
                            exc_next    = 1'b1;
                        end else begin
                            result_next = neg ? (DW'(0) - quot_step) : quot_step;
                            // Only 0x80000000 / -1 yields a positive quotient of 2^31.
                            exc_next    = ~neg & quot_step[DW-1];
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            booth  <= '0;
            dvs    <= '0;
            rem    <= '0;
            quot   <= '0;
            neg    <= 1'b0;
            dz     <= 1'b0;
            result <= '0;
            exc    <= 1'b0;
            rdy    <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            mcand  <= mcand_next;
            booth  <= booth_next;
            dvs    <= dvs_next;
            rem    <= rem_next;
            quot   <= quot_next;
            neg    <= neg_next;
            dz     <= dz_next;
            result <= result_next;
            exc    <= exc_next;
            rdy    <= rdy_next;
            busy_r <= busy_next;
        end
    end

    assign bus.data_result    = result;
    assign bus.data_exception = exc;
    assign bus.data_resultRDY = rdy;
    assign bus.busy           = busy_r;
endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiplier/divider that sits in the execute stage.
- Responds to the one-cycle assert_mult / assert_div requests issued by pipeline control.
- Returns the result together with a one-cycle ready strobe and an exception flag.
- Pipeline control stalls on busy and muxes data_result into the X/M latch when data_resultRDY fires.

Parameters:
- None. The datapath is fixed at 32 bits and the iteration count is fixed at 32.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ctrl_MULT  in  1  start-multiply pulse (driven by assert_mult)
- ctrl_DIV  in  1  start-divide pulse (driven by assert_div)
- data_operandA  in  32  signed multiplicand / dividend; sampled only in the start cycle
- data_operandB  in  32  signed multiplier / divisor; sampled only in the start cycle
- data_result  out  32  signed product low word or quotient; held until the next start
- data_exception  out  1  overflow or divide-by-zero flag; valid with data_result
- data_resultRDY  out  1  one-cycle strobe; data_result and data_exception are valid in this cycle
- busy  out  1  high while an operation is in flight

Behaviour:
- Reset (reset high at a clock edge):
  - State goes to IDLE; iteration counter = 0.
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0.
  - Reset overrides any start pulse in the same cycle.
  - Reset mid-operation aborts it; no RDY strobe is produced.
- States: IDLE, MULT, DIV, DONE.
  - IDLE --ctrl_MULT--> MULT
  - IDLE --ctrl_DIV--> DIV
  - MULT/DIV --counter==31--> DONE
  - DONE --> IDLE, or directly to MULT/DIV if a start pulse is present.
- Start cycle (cycle 0):
  - The edge that samples ctrl_MULT or ctrl_DIV high latches both operands and clears the counter.
  - busy = 1 from cycle 1.
  - If ctrl_MULT and ctrl_DIV are both high, MULT wins.
- Latency:
  - One iteration per cycle; 32 iterations.
  - data_resultRDY = 1 in cycle 33 exactly, for one cycle; busy = 0 in that cycle.
  - data_result and data_exception update in the same cycle as RDY and hold until the next RDY or reset.
- Restart: a start pulse seen while in MULT or DIV aborts the current operation and restarts with the new operands. The aborted operation never raises RDY.
- Multiply:
  - Radix-2 Booth over a 65-bit {acc, multiplier, q-1} register; one arithmetic shift per cycle.
  - data_result = product[31:0].
  - data_exception = 1 iff product[63:31] is not all zeros and not all ones (signed overflow).
- Divide:
  - Non-restoring division on operand magnitudes; quotient sign = signA XOR signB; truncation toward zero; remainder discarded.
  - Divisor == 0: data_result = 0, data_exception = 1, at the full 33-cycle latency.
  - 0x80000000 / 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
  - Dividend 0 with a nonzero divisor: data_result = 0, data_exception = 0.
- Operand inputs are ignored outside the start cycle. The pipeline may change them freely while busy.
- Start pulses are level-sampled each cycle. Holding ctrl high for multiple cycles restarts the operation every cycle; control must drive single-cycle pulses.

Test Plan:
- Multiply 7 by −3 (A=7, B=0xFFFFFFFD, ctrl_MULT pulse at cycle 0) -> RDY only at cycle 33; data_result = 0xFFFFFFEB; exception = 0; busy high in cycles 1–32.
- Multiply overflow: A=0x00010000, B=0x00010000, MULT -> result = 0x00000000, exception = 1. Then A=0x0000FFFF, B=0x00010000 -> result = 0xFFFF0000, exception = 1.
- Divide: A=−7, B=2 -> result 0xFFFFFFFD (−3), exception 0. A=100, B=−7 -> result 0xFFFFFFF2 (−14), exception 0.
- Divide edge cases:
  - A=5, B=0 -> result 0, exception 1, RDY at cycle 33.
  - A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
- Restart and priority:
  - MULT 3×4 at cycle 0, then DIV 20/5 at cycle 10 -> single RDY at cycle 43 with result 4; no RDY at cycle 33.
  - MULT and DIV both high -> multiply result returned.
- Reset mid-operation: reset at cycle 15 of a multiply -> all outputs 0 next cycle; no RDY ever. A new DIV 9/3 afterwards -> result 3 after 33 cycles.
